// File: rtl/mem_arbiter.sv
// Shares the memory controller port between CPU and DMA; DMA wins ties unless MEM_ARB_ROUND_ROBIN_EN.
// Latency: grant 1 cycle after request; ack/read data/memory strobes are combinational while granted.
// Backpressure: the non-owner's request is held off (ack=0) until the owner releases and mem_ack falls.
module mem_arbiter #(
   parameter int ADDR_W  = 18,
   parameter int WORD_W  = 36,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_write_data,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic              cpu_user,
   output logic [WORD_W-1:0] cpu_read_data,
   output logic              cpu_ack,
   output logic              cpu_nxm,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [WORD_W-1:0] dma_write_data,
   input  logic              dma_read,
   input  logic              dma_write,
   input  logic              dma_user,
   output logic [WORD_W-1:0] dma_read_data,
   output logic              dma_ack,
   output logic              dma_nxm,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_user,
   input  logic [WORD_W-1:0] mem_read_data,
   input  logic              mem_ack
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GRANT, NXM, RELEASE} state_t;

   state_t          state;
   logic            owner;      // 1 = DMA owns the port
   logic [CW-1:0]   cnt;
   logic            cpu_req, dma_req, own_req, own_rd, own_wr;
   logic            tie_dma;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic            last_dma;
   assign tie_dma = ~last_dma;
`else
   assign tie_dma = 1'b1;
`endif

   assign cpu_req = cpu_read | cpu_write;
   assign dma_req = dma_read | dma_write;
   assign own_rd  = owner ? dma_read  : cpu_read;
   assign own_wr  = owner ? dma_write : cpu_write;
   assign own_req = own_rd | own_wr;

   assign cpu_read_data = mem_read_data;
   assign dma_read_data = mem_read_data;

   always_comb begin
      mem_addr       = '0;
      mem_write_data = '0;
      mem_user       = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      cpu_ack        = 1'b0;
      cpu_nxm        = 1'b0;
      dma_ack        = 1'b0;
      dma_nxm        = 1'b0;
      if (state != IDLE) begin
         mem_addr       = owner ? dma_addr       : cpu_addr;
         mem_write_data = owner ? dma_write_data : cpu_write_data;
         mem_user       = owner ? dma_user       : cpu_user;
      end
      case (state)
         GRANT: begin
            // read+write together is a write
            mem_write = own_wr;
            mem_read  = own_rd & ~own_wr;
            cpu_ack   = ~owner & mem_ack;
            dma_ack   = owner & mem_ack;
         end
         NXM: begin
            cpu_ack = ~owner;
            cpu_nxm = ~owner;
            dma_ack = owner;
            dma_nxm = owner;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         cnt   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_dma <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (dma_req && (!cpu_req || tie_dma)) begin
                  owner <= 1'b1;
                  state <= GRANT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_dma <= 1'b1;
`endif
               end else if (cpu_req) begin
                  owner <= 1'b0;
                  state <= GRANT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_dma <= 1'b0;
`endif
               end
            end
            GRANT: begin
               if (!own_req)
                  state <= RELEASE;
               else if (mem_ack)
                  cnt <= '0;
               else if (cnt == CW'(TIMEOUT - 1))
                  state <= NXM;
               else
                  cnt <= cnt + 1'b1;
            end
            NXM: begin
               if (!own_req)
                  state <= RELEASE;
            end
            RELEASE: begin
               // controller must see the request drop before anyone is granted again
               if (!mem_ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table through a scoreboard, plus tie, abort-free release and reset sequences.
module tb_mem_arbiter;

   localparam int AW = 18;
   localparam int WW = 36;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
   logic [WW-1:0] cpu_write_data, dma_write_data, mem_write_data;
   logic [WW-1:0] cpu_read_data, dma_read_data, mem_read_data;
   logic          cpu_read, cpu_write, cpu_user, cpu_ack, cpu_nxm;
   logic          dma_read, dma_write, dma_user, dma_ack, dma_nxm;
   logic          mem_read, mem_write, mem_user, mem_ack;

   int checks = 0;
   int errors = 0;

   int            mm_delay;   // 0 = never ack
   logic [WW-1:0] mm_data;
   int            mm_cnt;

   typedef struct {
      bit            dma;
      bit            rd;
      bit            wr;
      bit            user;
      logic [AW-1:0] addr;
      logic [WW-1:0] wdata;
      int            delay;
      logic [WW-1:0] rdata;
      bit            exp_rd;
      bit            exp_wr;
      int            exp_lat;
      bit            exp_nxm;
   } vec_t;

   vec_t vecs[6];
   vec_t sb[$];

   mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_user(cpu_user), .cpu_read_data(cpu_read_data),
      .cpu_ack(cpu_ack), .cpu_nxm(cpu_nxm),
      .dma_addr(dma_addr), .dma_write_data(dma_write_data), .dma_read(dma_read),
      .dma_write(dma_write), .dma_user(dma_user), .dma_read_data(dma_read_data),
      .dma_ack(dma_ack), .dma_nxm(dma_nxm),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
      .mem_write(mem_write), .mem_user(mem_user), .mem_read_data(mem_read_data),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // memory controller model: ack after mm_delay cycles of request, held until request drops
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         mem_ack       <= 1'b0;
         mem_read_data <= '0;
         mm_cnt        <= 0;
      end else if (mem_read || mem_write) begin
         if (!mem_ack) begin
            mm_cnt <= mm_cnt + 1;
            if (mm_delay > 0 && mm_cnt + 1 >= mm_delay) begin
               mem_ack       <= 1'b1;
               mem_read_data <= mm_data;
            end
         end
      end else begin
         mem_ack       <= 1'b0;
         mem_read_data <= '0;
         mm_cnt        <= 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'o%0o expected 'o%0o", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      if (v.dma) begin
         dma_addr = v.addr; dma_write_data = v.wdata; dma_user = v.user;
         dma_read = v.rd;   dma_write = v.wr;
      end else begin
         cpu_addr = v.addr; cpu_write_data = v.wdata; cpu_user = v.user;
         cpu_read = v.rd;   cpu_write = v.wr;
      end
   endtask

   task automatic do_txn(input vec_t v);
      vec_t e;
      int   j;
      logic own_ack, own_nxm, oth_ack, oth_nxm;
      mm_delay = v.delay;
      mm_data  = v.rdata;
      drive(v);
      sb.push_back(v);
      #1;
      check("no_early_strobe", {62'd0, mem_read, mem_write}, 64'd0);
      tick();
      j = 0;
      check("grant_rd", {63'd0, mem_read}, {63'd0, v.exp_rd});
      check("grant_wr", {63'd0, mem_write}, {63'd0, v.exp_wr});
      while (!(v.dma ? dma_ack : cpu_ack) && j < 200) begin
         tick();
         j++;
      end
      e = sb.pop_front();
      own_ack = e.dma ? dma_ack : cpu_ack;
      own_nxm = e.dma ? dma_nxm : cpu_nxm;
      oth_ack = e.dma ? cpu_ack : dma_ack;
      oth_nxm = e.dma ? cpu_nxm : dma_nxm;
      check("ack_latency", 64'(j), 64'(e.exp_lat));
      check("owner_ack", {63'd0, own_ack}, 64'd1);
      check("owner_nxm", {63'd0, own_nxm}, {63'd0, e.exp_nxm});
      check("other_ack_nxm", {62'd0, oth_ack, oth_nxm}, 64'd0);
      if (e.exp_nxm) begin
         check("nxm_strobes_low", {62'd0, mem_read, mem_write}, 64'd0);
      end else begin
         check("mem_addr", 64'(mem_addr), 64'(e.addr));
         check("mem_user", {63'd0, mem_user}, {63'd0, e.user});
         check("mem_strobes", {62'd0, mem_read, mem_write}, {62'd0, e.exp_rd, e.exp_wr});
         if (e.exp_wr) check("mem_wdata", 64'(mem_write_data), 64'(e.wdata));
         if (e.exp_rd) begin
            check("owner_rdata", 64'(e.dma ? dma_read_data : cpu_read_data), 64'(e.rdata));
            check("other_rdata", 64'(e.dma ? cpu_read_data : dma_read_data), 64'(e.rdata));
         end
      end
      if (e.dma) begin dma_read = 1'b0; dma_write = 1'b0; end
      else       begin cpu_read = 1'b0; cpu_write = 1'b0; end
      #1;
      check("drop_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      repeat (3) tick();
   endtask

   initial begin
      int            j;
      vec_t          d;
      logic [AW-1:0] exp_addr;

      //          dma rd wr us addr          wdata             dly rdata              erd ewr lat nxm
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 18'o001000, 36'o0,            5, 36'o123456701234, 1'b1, 1'b0, 5,  1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 18'o000777, 36'o777777000000, 3, 36'o0,            1'b0, 1'b1, 3,  1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 18'o777777, 36'o525252525252, 1, 36'o0,            1'b0, 1'b1, 1,  1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 18'o000004, 36'o0,            2, 36'o000000000001, 1'b1, 1'b0, 2,  1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 18'o400000, 36'o111111111111, 0, 36'o0,            1'b0, 1'b1, TO, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 18'o123456, 36'o707070707070, 4, 36'o0,            1'b0, 1'b1, 4,  1'b0};

      reset = 1'b1;
      cpu_addr = '0; cpu_write_data = '0; cpu_read = 0; cpu_write = 0; cpu_user = 0;
      dma_addr = '0; dma_write_data = '0; dma_read = 0; dma_write = 0; dma_user = 0;
      mm_delay = 0; mm_data = '0;
      repeat (2) tick();
      check("reset_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      check("reset_acks", {60'd0, cpu_ack, cpu_nxm, dma_ack, dma_nxm}, 64'd0);
      check("reset_addr_user", {45'd0, mem_addr, mem_user}, 64'd0);
      reset = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 6; i++) do_txn(vecs[i]);

      // simultaneous requests: DMA first, CPU after DMA drops and mem_ack falls
      mm_delay = 2; mm_data = '0;
      cpu_addr = 18'o000100; cpu_read = 1'b1;
      dma_addr = 18'o000200; dma_write_data = 36'o1; dma_write = 1'b1;
      tick();
      check("tie1_owner_dma", 64'(mem_addr), 64'(18'o000200));
      j = 0;
      while (!dma_ack && j < 50) begin tick(); j++; end
      check("tie1_dma_ack", {63'd0, dma_ack}, 64'd1);
      check("tie1_cpu_waits", {63'd0, cpu_ack}, 64'd0);
      dma_write = 1'b0;
      j = 0;
      while (!(mem_read && mem_addr == 18'o000100) && j < 20) begin tick(); j++; end
      check("tie1_cpu_gap", 64'(j), 64'd3);
      j = 0;
      while (!cpu_ack && j < 50) begin tick(); j++; end
      check("tie1_cpu_ack", {63'd0, cpu_ack}, 64'd1);
      cpu_read = 1'b0;
      repeat (3) tick();

      // a lone DMA grant makes DMA the last owner before the second tie
      d = '{1'b1, 1'b1, 1'b0, 1'b0, 18'o000300, 36'o0, 2, 36'o246, 1'b1, 1'b0, 2, 1'b0};
      do_txn(d);
      mm_delay = 2;
      cpu_addr = 18'o000101; cpu_read = 1'b1;
      dma_addr = 18'o000201; dma_read = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_addr = 18'o000101;
`else
      exp_addr = 18'o000201;
`endif
      tick();
      check("tie2_owner", 64'(mem_addr), 64'(exp_addr));
      j = 0;
      while (!(cpu_ack || dma_ack) && j < 50) begin tick(); j++; end
      check("tie2_done", {63'd0, cpu_ack | dma_ack}, 64'd1);
      cpu_read = 1'b0; dma_read = 1'b0;
      repeat (4) tick();

      // reset in the middle of a DMA grant
      mm_delay = 0;
      dma_addr = 18'o000555; dma_write_data = 36'o3; dma_user = 1'b1; dma_write = 1'b1;
      repeat (4) tick();
      check("pre_reset_grant", {63'd0, mem_write}, 64'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      check("rst_acks", {60'd0, cpu_ack, cpu_nxm, dma_ack, dma_nxm}, 64'd0);
      check("rst_addr_user", {45'd0, mem_addr, mem_user}, 64'd0);
      check("rst_wdata", 64'(mem_write_data), 64'd0);
      dma_write = 1'b0; dma_user = 1'b0;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("post_reset_idle", {62'd0, mem_read, mem_write}, 64'd0);
      d = '{1'b0, 1'b1, 1'b0, 1'b0, 18'o000042, 36'o0, 1, 36'o765, 1'b1, 1'b0, 1, 1'b0};
      do_txn(d);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
